// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xbar_pkg
// Purpose : Shared beat record and round-robin pointer helper for ntom_xbar.
// Rev     : 1.0  initial release
// ============================================================================
package xbar_pkg;

    localparam int XBAR_PLD_W = 32;
    localparam int XBAR_SRC_W = 3;

    // Default-width view of a buffered beat; the top re-declares it with its own widths.
    typedef struct packed {
        logic [XBAR_PLD_W-1:0] pld;
        logic                  last;
        logic [XBAR_SRC_W-1:0] src;
    } xbar_beat_t;

    function automatic int unsigned ptr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_rr_lock_arb.sv
`default_nettype none
// ============================================================================
// Module  : xbar_rr_lock_arb
// Purpose : Per-output round-robin arbiter with optional packet lock.
// Rev     : 1.0  initial release
// ============================================================================
module xbar_rr_lock_arb
    import xbar_pkg::*;
#(
    parameter int  N        = 8,
    parameter int  PKT_LOCK = 1,
    localparam int SRC_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_last,
    input  logic             i_accept,
    output logic [N-1:0]     o_grant,
    output logic [SRC_W-1:0] o_win
);

    logic [SRC_W-1:0] r_ptr;
    logic [SRC_W-1:0] r_owner;
    logic             r_lock;
    logic             w_found;
    logic             w_hs;
    int               w_idx;

    always_comb begin
        o_grant = '0;
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        if (r_lock) begin
            // The owner keeps the output even while it idles mid-packet.
            o_win            = r_owner;
            o_grant[r_owner] = i_req[r_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N) w_idx = w_idx - N;
                if (!w_found && i_req[w_idx[SRC_W-1:0]]) begin
                    w_found                   = 1'b1;
                    o_grant[w_idx[SRC_W-1:0]] = 1'b1;
                    o_win                     = w_idx[SRC_W-1:0];
                end
            end
        end
    end

    assign w_hs = (|o_grant) & i_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_lock  <= 1'b0;
        end else if (w_hs) begin
            if (PKT_LOCK != 0 && !i_last[o_win]) begin
                r_lock  <= 1'b1;
                r_owner <= o_win;
            end else begin
                r_lock  <= 1'b0;
                r_ptr   <= SRC_W'(ptr_next(32'(o_win), N));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ntom_xbar.sv
`default_nettype none
// ============================================================================
// Module  : ntom_xbar
// Purpose : N-input, M-output request crossbar with per-output RR arbiter
//           and registered 2-entry skid slice.
// Rev     : 1.0  initial release
// ============================================================================
module ntom_xbar
    import xbar_pkg::*;
#(
    parameter int  N         = 8,
    parameter int  M         = 4,
    parameter int  PLD_WIDTH = 32,
    parameter int  PKT_LOCK  = 1,
    localparam int SEL_W     = (M > 1) ? $clog2(M) : 1,
    localparam int SRC_W     = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           in_vld,
    input  logic [N*PLD_WIDTH-1:0] in_pld,
    input  logic [N-1:0]           in_last,
    input  logic [N*SEL_W-1:0]     in_select,
    output logic [N-1:0]           in_rdy,
    output logic [M-1:0]           out_vld,
    output logic [M*PLD_WIDTH-1:0] out_pld,
    output logic [M-1:0]           out_last,
    output logic [M*SRC_W-1:0]     out_src,
    input  logic [M-1:0]           out_rdy
);

    typedef struct packed {
        logic [PLD_WIDTH-1:0] pld;
        logic                 last;
        logic [SRC_W-1:0]     src;
    } beat_t;

    logic [M*N-1:0] w_rdy_flat;

    for (genvar o = 0; o < M; o++) begin : g_out
        logic [N-1:0]     w_req;
        logic [N-1:0]     w_grant;
        logic [SRC_W-1:0] w_win;
        logic             w_accept;
        logic             w_push;
        logic             w_pop;
        logic [1:0]       w_cnt_nxt;
        beat_t            w_beat;
        beat_t            r_buf [2];
        logic             r_rd;
        logic             r_wr;
        logic [1:0]       r_cnt;
        logic             r_slice_rdy;

        for (genvar i = 0; i < N; i++) begin : g_req
            assign w_req[i] = in_vld[i] && (in_select[i*SEL_W +: SEL_W] == SEL_W'(o));
        end

        xbar_rr_lock_arb #(
            .N        (N),
            .PKT_LOCK (PKT_LOCK)
        ) u_arb (
            .clk      (clk),
            .rst      (rst),
            .i_req    (w_req),
            .i_last   (in_last),
            .i_accept (w_accept),
            .o_grant  (w_grant),
            .o_win    (w_win)
        );

        // Slice readiness is a flop, so out_rdy never reaches in_rdy combinationally.
        assign w_accept                 = r_slice_rdy & ~rst;
        assign w_push                   = (|w_grant) & w_accept;
        assign w_pop                    = out_vld[o] & out_rdy[o];
        assign w_cnt_nxt                = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        assign w_rdy_flat[o*N +: N]     = w_grant & {N{w_accept}};

        always_comb begin
            w_beat.pld  = in_pld[int'(w_win)*PLD_WIDTH +: PLD_WIDTH];
            w_beat.last = in_last[w_win];
            w_beat.src  = w_win;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_buf[0]    <= '0;
                r_buf[1]    <= '0;
                r_rd        <= 1'b0;
                r_wr        <= 1'b0;
                r_cnt       <= 2'd0;
                r_slice_rdy <= 1'b1;
            end else begin
                if (w_push) begin
                    r_buf[r_wr] <= w_beat;
                    r_wr        <= ~r_wr;
                end
                if (w_pop) r_rd <= ~r_rd;
                r_cnt       <= w_cnt_nxt;
                r_slice_rdy <= (w_cnt_nxt < 2'd2);
            end
        end

        assign out_vld[o]                          = (r_cnt != 2'd0);
        assign out_pld[o*PLD_WIDTH +: PLD_WIDTH]   = r_buf[r_rd].pld;
        assign out_last[o]                         = r_buf[r_rd].last;
        assign out_src[o*SRC_W +: SRC_W]           = r_buf[r_rd].src;
    end

    always_comb begin
        in_rdy = '0;
        for (int o = 0; o < M; o++) in_rdy = in_rdy | w_rdy_flat[o*N +: N];
    end

endmodule
`default_nettype wire
